pipeline_arith_hs: RTL and testbench

//  Parametrised 3-stage arithmetic pipeline computing F = ((A+B)+(C-D))*D, with

---
 rtl/pipeline_arith_hs_pkg.sv | 27 ++
 rtl/pipeline_arith_hs_ctrl.sv | 27 ++
 rtl/pipeline_arith_hs.sv | 110 +++++++++++
 tb/tb_pipeline_arith_hs.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_arith_hs_pkg.sv
// Shared definitions for the arithmetic pipeline family: stage count, result
// mode constants and the internal width helpers.
package pipeline_arith_hs_pkg;

  localparam int STAGES = 3;

  // Result handling modes for the N-bit output
  localparam bit SAT_WRAP  = 1'b0;  // keep low N bits
  localparam bit SAT_CLAMP = 1'b1;  // clamp to [0, 2^N-1]

  // A+B, and C-D as a signed value: both fit in N+1 bits
  function automatic int w_x1(input int n);
    return n + 1;
  endfunction

  // A+B+C-D spans -(2^N-1) .. 3*(2^N-1); that range needs N+3 signed bits,
  // otherwise large A+B+C with a small nonzero D would wrap before the multiply
  function automatic int w_x3(input int n);
    return n + 3;
  endfunction

  // |(A+B+C-D)*D| stays below 2^(2N+2), so 2N+3 signed bits hold it exactly
  function automatic int w_p(input int n);
    return 2 * n + 3;
  endfunction

endpackage

// File: rtl/pipeline_arith_hs_ctrl.sv
// One pipeline stage's handshake control: valid flop, load strobe and the
// ready it offers upstream. The ready chain is purely combinational so a
// full pipeline still moves every cycle when the consumer is taking data.
module pipe_stage_ctrl (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic up_valid,
  input  logic down_ready,
  output logic v,
  output logic load,
  output logic up_ready
);

  // Empty stage or one whose contents leave this cycle can take a new item;
  // flush blocks intake so nothing slips in while everything is discarded
  assign up_ready = !rst && !flush && (!v || down_ready);
  assign load     = up_valid && up_ready;

  // Valid bit: cleared by reset/flush, refilled (or drained) whenever the stage moves
  always_ff @(posedge clk) begin
    if (rst)           v <= 1'b0;
    else if (flush)    v <= 1'b0;
    else if (up_ready) v <= up_valid;
  end

endmodule

// File: rtl/pipeline_arith_hs.sv
// Three-stage F = ((A+B)+(C-D))*D pipeline with valid/ready at both ends,
// exact internal arithmetic and a clamped or wrapped N-bit result.
module pipeline_arith_hs
  import pipeline_arith_hs_pkg::*;
#(
  parameter int N   = 10,
  parameter bit SAT = SAT_CLAMP
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic [N-1:0] C,
  input  logic [N-1:0] D,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] F,
  output logic         ovf
);

  localparam int W_X1 = w_x1(N);
  localparam int W_X3 = w_x3(N);
  localparam int W_P  = w_p(N);

  // vld_pipe[0] is the producer's valid, vld_pipe[k] the valid of stage k
  logic [STAGES:0] vld_pipe;
  logic [STAGES:1] load;
  logic            rdy2, rdy3;

  assign vld_pipe[0] = in_valid;
  assign out_valid   = vld_pipe[STAGES];

  pipe_stage_ctrl u_ctrl1 (
    .clk, .rst, .flush,
    .up_valid(vld_pipe[0]), .down_ready(rdy2),
    .v(vld_pipe[1]), .load(load[1]), .up_ready(in_ready)
  );

  pipe_stage_ctrl u_ctrl2 (
    .clk, .rst, .flush,
    .up_valid(vld_pipe[1]), .down_ready(rdy3),
    .v(vld_pipe[2]), .load(load[2]), .up_ready(rdy2)
  );

  pipe_stage_ctrl u_ctrl3 (
    .clk, .rst, .flush,
    .up_valid(vld_pipe[2]), .down_ready(out_ready),
    .v(vld_pipe[3]), .load(load[3]), .up_ready(rdy3)
  );

  // Datapath registers
  logic        [W_X1-1:0] x1;
  logic signed [W_X1-1:0] x2;
  logic        [N-1:0]    d1, d2;
  logic signed [W_X3-1:0] x3;

  logic signed [W_X1-1:0] x2_nxt;
  logic signed [W_X3-1:0] x3_nxt;
  logic signed [W_P-1:0]  p;
  logic        [N-1:0]    f_nxt;
  logic                   ovf_nxt;

  assign x2_nxt = $signed({1'b0, C}) - $signed({1'b0, D});
  assign x3_nxt = $signed({2'b00, x1}) + $signed({{2{x2[W_X1-1]}}, x2});
  assign p      = $signed({{(W_P-W_X3){x3[W_X3-1]}}, x3})
                * $signed({{(W_P-N){1'b0}}, d2});

  // Anything negative or with bits set above N-1 is outside the N-bit range
  assign ovf_nxt = p[W_P-1] | (|p[W_P-2:N]);

  // Result shaping: wrap takes the low bits, clamp pins to the range ends
  always_comb begin
    f_nxt = p[N-1:0];
    if (SAT) begin
      if (p[W_P-1])          f_nxt = '0;
      else if (|p[W_P-2:N])  f_nxt = '1;
    end
  end

  // Each stage's data loads only on its handshake, so stalled stages hold
  always_ff @(posedge clk) begin
    if (rst) begin
      x1  <= '0;
      x2  <= '0;
      d1  <= '0;
      x3  <= '0;
      d2  <= '0;
      F   <= '0;
      ovf <= 1'b0;
    end else begin
      if (load[1]) begin
        x1 <= {1'b0, A} + {1'b0, B};
        x2 <= x2_nxt;
        d1 <= D;
      end
      if (load[2]) begin
        x3 <= x3_nxt;
        d2 <= d1;
      end
      if (load[3]) begin
        F   <= f_nxt;
        ovf <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_arith_hs.sv
// Bench for pipeline_arith_hs: clamp and wrap instances share the stimulus;
// a queue of expected results, computed with plain integer arithmetic,
// scores every output handshake.
module tb_pipeline_arith_hs;

  localparam int N = 10;
  localparam longint LIM = (64'sd1 <<< N) - 1;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, out_ready;
  logic [N-1:0] a, b, c, d;
  logic         in_ready, in_ready_w, vo_s, vo_w, ovf_s, ovf_w;
  logic [N-1:0] f_s, f_w;

  always #5 clk = ~clk;

  pipeline_arith_hs #(.N(N), .SAT(1'b1)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .C(c), .D(d),
    .out_valid(vo_s), .out_ready(out_ready), .F(f_s), .ovf(ovf_s)
  );

  pipeline_arith_hs #(.N(N), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .A(a), .B(b), .C(c), .D(d),
    .out_valid(vo_w), .out_ready(out_ready), .F(f_w), .ovf(ovf_w)
  );

  typedef struct {
    longint fs;
    longint fw;
    longint ov;
  } exp_t;

  exp_t   q[$];
  longint obs_f[$], obs_w[$], obs_o[$], obs_c[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc_n  = 0;
  bit     acc;

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  function automatic exp_t ref_model(input int ai, input int bi, input int ci, input int di);
    longint p;
    exp_t   e;
    p    = longint'(ai + bi + ci - di) * longint'(di);
    e.ov = (p < 0 || p > LIM) ? 1 : 0;
    e.fs = (p < 0) ? 0 : ((p > LIM) ? LIM : p);
    e.fw = p & LIM;
    return e;
  endfunction

  function automatic logic [N-1:0] rnd_op();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return '0;
    if (r == 1) return '1;
    return N'($urandom_range(0, 1023));
  endfunction

  task automatic set_op(input int ai, input int bi, input int ci, input int di);
    a = N'(ai); b = N'(bi); c = N'(ci); d = N'(di);
  endtask

  // One cycle: let inputs settle, score handshakes due at the coming edge,
  // then return at the following falling edge with outputs stable.
  task automatic tick();
    exp_t e;
    #1;
    cyc_n++;
    acc = 1'b0;
    if (rst) begin
      q.delete();
    end else begin
      if (vo_s && out_ready) begin
        obs_f.push_back(f_s); obs_w.push_back(f_w);
        obs_o.push_back(ovf_s); obs_c.push_back(cyc_n);
        if (q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = q.pop_front();
          chk("f_sat", f_s, e.fs);
          chk("f_wrap", f_w, e.fw);
          chk("ovf_sat", ovf_s, e.ov);
          chk("ovf_wrap", ovf_w, e.ov);
          chk("vld_wrap", vo_w, 1);
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        chk("rdy_wrap", in_ready_w, 1);
        q.push_back(ref_model(a, b, c, d));
      end
      if (flush) q.delete();
    end
    @(negedge clk);
  endtask

  task automatic drain(input int n);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  int t2[8][4] = '{'{10,12,6,3}, '{10,10,5,3}, '{20,11,1,4}, '{15,10,8,2},
                   '{8,15,5,0},  '{10,20,5,3}, '{10,10,30,1}, '{30,1,2,4}};
  int t2_f[8]  = '{75, 66, 112, 62, 0, 96, 49, 116};
  int t4[5][4] = '{'{1,2,3,4}, '{5,6,7,8}, '{9,9,9,9}, '{100,50,20,7}, '{3,3,3,3}};

  initial begin
    int base, idx, sent;
    logic [N-1:0] fh;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_op(0, 0, 0, 0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b0;
    #1;
    chk("rst_vo", vo_s, 0);
    chk("rst_f", f_s, 0);
    chk("rst_ovf", ovf_s, 0);
    chk("rst_rdy", in_ready, 1);
    @(negedge clk);

    // single item: valid appears two edges after the accepting edge
    out_ready = 1'b1;
    set_op(10, 12, 6, 3); in_valid = 1'b1;
    tick();
    chk("t1_acc", acc, 1);
    in_valid = 1'b0;
    chk("t1_lat_a", vo_s, 0);
    tick();
    chk("t1_lat_b", vo_s, 0);
    tick();
    chk("t1_lat_c", vo_s, 1);
    chk("t1_f", f_s, 75);
    chk("t1_ovf", ovf_s, 0);
    drain(4);

    // back-to-back stream
    base = obs_f.size();
    for (int i = 0; i < 8; i++) begin
      set_op(t2[i][0], t2[i][1], t2[i][2], t2[i][3]); in_valid = 1'b1;
      tick();
    end
    drain(6);
    chk("t2_cnt", obs_f.size() - base, 8);
    for (int i = 0; i < 8 && base + i < obs_f.size(); i++) begin
      chk("t2_f", obs_f[base + i], t2_f[i]);
      if (i > 0) chk("t2_consec", obs_c[base + i] - obs_c[base + i - 1], 1);
    end

    // overflow high and negative
    base = obs_f.size();
    set_op(1023, 1023, 0, 1023); in_valid = 1'b1; tick();
    set_op(0, 0, 0, 5); tick();
    drain(6);
    chk("t3_cnt", obs_f.size() - base, 2);
    if (obs_f.size() >= base + 2) begin
      chk("t3_hi_sat", obs_f[base], 1023);
      chk("t3_hi_wrap", obs_w[base], 1);
      chk("t3_hi_ovf", obs_o[base], 1);
      chk("t3_neg_sat", obs_f[base + 1], 0);
      chk("t3_neg_wrap", obs_w[base + 1], 999);
      chk("t3_neg_ovf", obs_o[base + 1], 1);
    end

    // backpressure: capacity three, result held while stalled
    base = obs_f.size();
    out_ready = 1'b0; idx = 0;
    for (int i = 0; i < 8; i++) begin
      set_op(t4[idx][0], t4[idx][1], t4[idx][2], t4[idx][3]); in_valid = 1'b1;
      tick();
      if (acc) idx++;
    end
    chk("t4_acc3", idx, 3);
    chk("t4_rdy0", in_ready, 0);
    chk("t4_vo", vo_s, 1);
    fh = f_s;
    tick(); tick();
    chk("t4_hold", f_s, fh);
    out_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 5; i++) begin
      set_op(t4[idx][0], t4[idx][1], t4[idx][2], t4[idx][3]); in_valid = 1'b1;
      tick();
      if (acc) idx++;
    end
    chk("t4_acc5", idx, 5);
    drain(6);
    chk("t4_cnt", obs_f.size() - base, 5);

    // random valid/ready traffic
    sent = 0;
    for (int i = 0; i < 3000 && sent < 200; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = rnd_op(); b = rnd_op(); c = rnd_op(); d = rnd_op();
      tick();
      if (acc) sent++;
    end
    drain(8);
    chk("t5_sent", sent, 200);
    chk("t5_left", q.size(), 0);

    // flush with a full pipe and a concurrent offer
    out_ready = 1'b0;
    for (int i = 0; i < 10 && in_ready; i++) begin
      a = rnd_op(); b = rnd_op(); c = rnd_op(); d = rnd_op(); in_valid = 1'b1;
      tick();
    end
    chk("t6_full", vo_s, 1);
    flush = 1'b1; in_valid = 1'b1; set_op(7, 7, 7, 7);
    #1;
    chk("t6_rdy", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t6_vo", vo_s, 0);
    base = obs_f.size();
    drain(5);
    chk("t6_none", obs_f.size() - base, 0);

    // reset mid-stream, then resume
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rnd_op(); b = rnd_op(); c = rnd_op(); d = rnd_op(); in_valid = 1'b1;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("t6_rst_vo", vo_s, 0);
    chk("t6_rst_f", f_s, 0);
    chk("t6_rst_fw", f_w, 0);
    chk("t6_rst_ovf", ovf_s, 0);
    base = obs_f.size();
    for (int i = 0; i < 4; i++) begin
      a = rnd_op(); b = rnd_op(); c = rnd_op(); d = rnd_op(); in_valid = 1'b1;
      tick();
    end
    drain(6);
    chk("t6_resume", obs_f.size() - base, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
